booth_seq_ctrl: RTL and testbench

Sequencing front-end for the radix-2 Booth multiplier datapath (M register, HQ/LQ/Q_-1 shift chain, add/sub unit).
- Accepts an operand pair over a valid/ready request port and registers the operands.
- Drives the datapath control fields from the {LQ[0], Q_-1} pair that the datapath reports back.
- Captures the 2N-bit product and returns it over a valid/ready response port.
- Sits directly upstream of the datapath; one controller per datapath instance.

---
 rtl/booth_seq_ctrl.sv | 90 +++++++++
 tb/tb_booth_seq_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: radix-2 Booth multiplier sequencer; define BOOTH_PERF_CNT_EN to add the perf_cycles latency counter
module booth_seq_ctrl #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [N-1:0]   req_a,
  input  logic [N-1:0]   req_b,
  output logic [N-1:0]   op_a,
  output logic [N-1:0]   op_b,
  output logic           dp_clr,
  output logic           load_a,
  output logic           load_b,
  output logic           load_add,
  output logic           shift,
  output logic           add_sub,
  input  logic [1:0]     q_lsb,
  input  logic [2*N-1:0] dp_y,
  output logic           res_valid,
  input  logic           res_ready,
`ifdef BOOTH_PERF_CNT_EN
  output logic [$clog2(2*N+5)-1:0] perf_cycles,
`endif
  output logic [2*N-1:0] res_data
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] OP    = 3'd3;
  localparam logic [2:0] SHIFT = 3'd4;
  localparam logic [2:0] CAPT  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;
  logic [2:0]    state, nxt;
  logic [CW-1:0] cnt;
  logic          need_add, last;
  assign need_add = q_lsb[1] ^ q_lsb[0];
  assign last     = cnt == CW'(N - 1);
  always_comb begin
    req_ready = state == IDLE;
    dp_clr    = state == CLEAR;
    load_a    = state == LOAD;
    load_b    = state == LOAD;
    load_add  = state == OP && need_add;
    add_sub   = state == OP && q_lsb == 2'b01;
    shift     = state == SHIFT || (state == OP && !need_add);
    res_valid = state == DONE;
  end
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = req_valid ? CLEAR : IDLE;
      CLEAR:   nxt = LOAD;
      LOAD:    nxt = OP;
      OP:      nxt = need_add ? SHIFT : (last ? CAPT : OP);
      SHIFT:   nxt = last ? CAPT : OP;
      CAPT:    nxt = DONE;
      DONE:    nxt = res_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      res_data <= '0;
    end else begin
      state <= nxt;
      cnt   <= dp_clr ? '0 : (shift ? cnt + CW'(1) : cnt);
      if (state == IDLE && req_valid) begin
        op_a <= req_a;
        op_b <= req_b;
      end
      if (state == CAPT) res_data <= dp_y;
    end
  end
`ifdef BOOTH_PERF_CNT_EN
  localparam int PW = $clog2(2*N+5);
  // Loading 1 on accept counts the accept cycle itself, so DONE reads the full latency
  always_ff @(posedge clk) begin
    if (rst) perf_cycles <= '0;
    else if (state == IDLE && req_valid) perf_cycles <= PW'(1);
    else if (state != IDLE && state != DONE) perf_cycles <= perf_cycles + PW'(1);
  end
`endif
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb_booth_seq_ctrl: directed bench for booth_seq_ctrl with a Booth datapath model and a per-cycle scoreboard
module tb_booth_seq_ctrl;
  localparam int N = 8;
  logic clk = 0;
  logic rst = 1;
  logic req_valid = 0, req_ready, res_valid, res_ready = 1;
  logic [N-1:0] req_a = 0, req_b = 0, op_a, op_b;
  logic dp_clr, load_a, load_b, load_add, shift, add_sub;
  logic [1:0] q_lsb;
  logic [2*N-1:0] dp_y, res_data;
`ifdef BOOTH_PERF_CNT_EN
  logic [$clog2(2*N+5)-1:0] perf_cycles;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  booth_seq_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b),
    .dp_clr(dp_clr), .load_a(load_a), .load_b(load_b), .load_add(load_add),
    .shift(shift), .add_sub(add_sub), .q_lsb(q_lsb), .dp_y(dp_y),
    .res_valid(res_valid), .res_ready(res_ready),
`ifdef BOOTH_PERF_CNT_EN
    .perf_cycles(perf_cycles),
`endif
    .res_data(res_data)
  );

  // Datapath: M, HQ (one guard bit), LQ, Q_-1
  logic signed [N:0] hq = 0;
  logic [N-1:0] lq = 0, m = 0;
  logic q1 = 0;
  always @(posedge clk) begin
    if (rst || dp_clr) begin
      hq <= 0; lq <= 0; q1 <= 0; m <= 0;
    end else begin
      if (load_a) m <= op_a;
      if (load_b) lq <= op_b;
      if (load_add) hq <= add_sub ? hq + $signed({m[N-1], m}) : hq - $signed({m[N-1], m});
      if (shift) {hq, lq, q1} <= {hq[N], hq, lq};
    end
  end
  assign q_lsb = {lq[0], q1};
  assign dp_y  = {hq[N-1:0], lq};

  function automatic int adds_of(input logic [N-1:0] b);
    int n = 0;
    logic p = 0;
    for (int i = 0; i < N; i++) begin
      if (b[i] != p) n++;
      p = b[i];
    end
    return n;
  endfunction

  function automatic logic [2*N-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
    logic signed [2*N-1:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sb;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Transaction tracker: expectations captured at accept, activity counted per edge
  int acc_cnt = 0, cyc = 0, shf = 0, nadd = 0, exp_lat = 0, exp_add = 0;
  logic busy = 0, got_add = 0, first_as = 0;
  logic [2*N-1:0] exp_p = 0;
  always @(posedge clk) begin
    if (rst) busy <= 0;
    else if (req_valid && req_ready) begin
      busy <= 1; cyc <= 1; shf <= 0; nadd <= 0; got_add <= 0;
      exp_p <= prod(req_a, req_b);
      exp_add <= adds_of(req_b);
      exp_lat <= N + 4 + adds_of(req_b);
      acc_cnt <= acc_cnt + 1;
    end else if (busy) begin
      if (!res_valid) cyc <= cyc + 1;
      if (shift) shf <= shf + 1;
      if (load_add) begin
        nadd <= nadd + 1;
        if (!got_add) begin got_add <= 1; first_as <= add_sub; end
      end
      if (res_valid && res_ready) busy <= 0;
    end
  end

  logic chk_en = 0;
  int last_acc = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, !busy);
      chk("add_shift_excl", load_add & shift, 0);
      chk("add_sub_idle", add_sub & !load_add, 0);
      chk("res_valid_idle", res_valid & !busy, 0);
      if (res_valid) begin
        chk("res_data", res_data, exp_p);
`ifdef BOOTH_PERF_CNT_EN
        chk("perf_cycles", perf_cycles, exp_lat);
`endif
        if (last_acc != acc_cnt) begin
          last_acc = acc_cnt;
          chk("latency", cyc, exp_lat);
          chk("shift_pulses", shf, N);
          chk("add_pulses", nadd, exp_add);
        end
      end
    end
  end

  task automatic send(input logic [N-1:0] a, input logic [N-1:0] b);
    int prev;
    @(negedge clk);
    req_a = a; req_b = b; req_valid = 1;
    prev = acc_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (acc_cnt != prev) break;
    end
    chk("accept", acc_cnt - prev, 1);
    req_valid = 0;
  endtask

  task automatic wait_res();
    for (int i = 0; i < 100; i++) begin
      if (res_valid) break;
      @(negedge clk);
    end
    chk("res_timeout", res_valid, 1);
  endtask

  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic [2*N-1:0] exp_d, input int exp_l);
    send(a, b);
    wait_res();
    chk("lit_data", res_data, exp_d);
    chk("lit_latency", cyc, exp_l);
    @(negedge clk);
  endtask

  initial begin
    int prev;
    logic [2*N-1:0] held;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_ctrl", {dp_clr, load_a, load_b, load_add, shift, add_sub, res_valid}, 0);
    chk("rst_regs", {op_a, op_b, res_data}, 0);
`ifdef BOOTH_PERF_CNT_EN
    chk("rst_perf", perf_cycles, 0);
`endif
    rst = 0;
    chk_en = 1;
    run(8'd3, 8'd5, 16'h000F, 16);
    run(8'hFD, 8'd5, 16'hFFF1, 16);
    chk("first_add_sub", first_as, 0);
    run(8'h7F, 8'h00, 16'h0000, 12);
    chk("no_adds", nadd, 0);
    run(8'h80, 8'h55, 16'hD580, 20);
    run(8'h80, 8'h80, 16'h4000, 13);
    run(8'hFF, 8'hFF, 16'h0001, 13);
    // Backpressure with a competing request held high
    res_ready = 0;
    send(8'd9, 8'd7);
    wait_res();
    held = res_data;
    chk("bp_data", held, 16'h003F);
    req_a = 8'd2; req_b = 8'd2; req_valid = 1;
    prev = acc_cnt;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", res_valid, 1);
      chk("bp_hold", res_data, held);
      chk("bp_ready", req_ready, 0);
      chk("bp_no_accept", acc_cnt, prev);
    end
    res_ready = 1;
    @(negedge clk);
    chk("hs_idle", {res_valid, req_ready}, 2'b01);
    chk("hs_no_accept", acc_cnt, prev);
    @(negedge clk);
    chk("b2b_accept", acc_cnt - prev, 1);
    req_valid = 0;
    wait_res();
    chk("b2b_data", res_data, 16'h0004);
    chk("b2b_latency", cyc, 14);
    @(negedge clk);
    // Abort mid-operation
    send(8'h11, 8'h00);
    for (int i = 0; i < 30; i++) begin
      if (shf == 3) break;
      @(negedge clk);
    end
    chk("abort_shifts", shf, 3);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_ready", req_ready, 1);
    chk("abort_ctrl", {dp_clr, load_a, load_b, load_add, shift, add_sub, res_valid}, 0);
    chk("abort_res", res_data, 0);
    repeat (15) @(negedge clk);
    run(8'hF9, 8'h0C, 16'hFFAC, 14);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
